// File: rtl/ws2811_framebuffer.sv
// Double-buffered RGB pixel store for the ws2811 driver; swaps banks at frame wrap.
// Optional COPY_ON_SWAP_EN: after a swap, copy the shown frame into the back bank.
module ws2811_framebuffer #(
  parameter int NUM_LEDS = 60,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_red,
  input  logic [7:0]        wr_green,
  input  logic [7:0]        wr_blue,
  output logic              wr_ready,
  output logic              wr_err,
  input  logic              commit,
  output logic              swap_pending,
  output logic              swap_done
);

  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [ADDR_W:0] NUM = (ADDR_W+1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } state_e;

  state_e            state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic [23:0]       rgb_q, rgb_d;
  logic              wr_err_q, wr_err_d;

  logic [23:0] mem [2][NUM_LEDS];

  logic          boundary;
  logic          rd_in, wr_in;
  logic          wr_acc, wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;

`ifdef COPY_ON_SWAP_EN
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);
  logic [AW-1:0] cnt_q, cnt_d;
  logic          copy_we;
`endif

  assign rd_idx   = rd_addr[AW-1:0];
  assign wr_idx   = wr_addr[AW-1:0];
  assign rd_in    = {1'b0, rd_addr} < NUM;
  assign wr_in    = {1'b0, wr_addr} < NUM;
  assign boundary = (prev_addr_q != '0) && (rd_addr == '0);

  assign wr_ready     = (state_q == IDLE);
  assign swap_pending = (state_q == PENDING);
  assign wr_acc       = wr_en && wr_ready && !reset;
  assign wr_ok        = wr_acc && wr_in;
  assign wr_err_d     = wr_acc && !wr_in;

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    swap_done = 1'b0;
`ifdef COPY_ON_SWAP_EN
    cnt_d   = cnt_q;
    copy_we = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (commit) state_d = PENDING;
      end
      PENDING: begin
        if (boundary) begin
          bank_d    = ~bank_q;
          swap_done = 1'b1;
`ifdef COPY_ON_SWAP_EN
          state_d = COPY;
          cnt_d   = '0;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef COPY_ON_SWAP_EN
      COPY: begin
        copy_we = !reset;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Read uses bank_d so a swap is visible to the read issued in the swap cycle.
  always_comb begin
    rgb_d = '0;
    if (rd_in) rgb_d = mem[bank_d][rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      prev_addr_q <= '0;
      rgb_q       <= '0;
      wr_err_q    <= 1'b0;
`ifdef COPY_ON_SWAP_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      prev_addr_q <= rd_addr;
      rgb_q       <= rgb_d;
      wr_err_q    <= wr_err_d;
`ifdef COPY_ON_SWAP_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[~bank_q][wr_idx] <= {wr_red, wr_green, wr_blue};
`ifdef COPY_ON_SWAP_EN
    else if (copy_we) mem[~bank_q][cnt_q] <= mem[bank_q][cnt_q];
`endif
  end

  assign red    = rgb_q[23:16];
  assign green  = rgb_q[15:8];
  assign blue   = rgb_q[7:0];
  assign wr_err = wr_err_q;

endmodule
